// File: rtl/blink_arb_if.sv
// Bus bundle for blink_arb: requests and burst lengths in, LED drive and status out.
interface blink_arb_if;
    logic [3:0]  req;
    logic [15:0] blinks;
    logic        led;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        flg;

    modport master (
        output req, blinks,
        input  led, gnt, done, busy, flg
    );

    modport slave (
        input  req, blinks,
        output led, gnt, done, busy, flg
    );
endinterface

// File: rtl/blink_arb.sv
// Round-robin arbiter sharing one LED among four requesters; each winner gets a burst of
// on/off blinks followed by a gap phase, every phase lasting 2^CBITS cycles.
module blink_arb #(
    parameter int unsigned CBITS = 15,
    parameter int unsigned NREQ  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    blink_arb_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

    state_e             state_q, state_d;
    logic [CBITS-1:0]   cnt_q, cnt_d;
    logic [3:0]         rem_q, rem_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               led_q;

    logic               cnt_max;
    logic               found;
    logic [1:0]         win;
    logic [1:0]         cand;
    logic [3:0]         field;

    assign cnt_max = &cnt_q;

    // Search upward from ptr_q, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr_q + i[1:0];
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        field = bus.blinks[{win, 2'b00} +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == StIdle) ? '0 : cnt_q + 1'b1;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOn;
                    gnt_d   = 4'b0001 << win;
                    rem_d   = (field == 4'd0) ? 4'd1 : field;
                    ptr_d   = win + 2'd1;
                end
            end
            StOn: begin
                if (cnt_max) state_d = StOff;
            end
            StOff: begin
                if (cnt_max) begin
                    rem_d   = rem_q - 4'd1;
                    state_d = (rem_q > 4'd1) ? StOn : StGap;
                end
            end
            StGap: begin
                if (cnt_max) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            // Lags state by one cycle, giving the two-cycle request-to-LED latency.
            led_q   <= (state_q == StOn);
        end
    end

    assign bus.led  = led_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.flg  = (state_q != StIdle) && cnt_max;
    assign bus.done = (state_q == StGap && cnt_max) ? gnt_q : 4'b0000;

endmodule

// File: tb/tb_blink_arb.sv
// Scoreboard bench for blink_arb (CBITS=2): stimulus queues expected grant/done events,
// a negedge monitor pops and compares them; LED, flag and reset behaviour checked inline.
module tb_blink_arb;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        bit       is_done;
        logic [3:0] val;
        int       at;
    } ev_t;

    ev_t q[$];

    blink_arb_if bus ();

    blink_arb #(.CBITS(2), .NREQ(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic push(input bit is_done, input logic [3:0] val, input int at);
        ev_t e;
        e.is_done = is_done;
        e.val     = val;
        e.at      = at;
        q.push_back(e);
    endtask

    task automatic at_neg(input int c);
        @(negedge clk_i);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic handle(input bit is_done, input logic [3:0] val);
        ev_t e;
        if (q.size() == 0) begin
            chk(is_done ? "unexpected_done" : "unexpected_grant", {28'd0, val}, 32'd0);
        end else begin
            e = q.pop_front();
            chk("event_kind", {31'd0, is_done}, {31'd0, e.is_done});
            chk(is_done ? "done_value" : "grant_value", {28'd0, val}, {28'd0, e.val});
            chk(is_done ? "done_cycle" : "grant_cycle", cyc, e.at);
        end
    endtask

    // Monitor: grant events on gnt rising from zero, done events on any done pulse.
    initial begin
        logic [3:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge clk_i);
            if (bus.busy) chk("gnt_onehot", {31'd0, $onehot(bus.gnt)}, 32'd1);
            else          chk("gnt_idle_zero", {28'd0, bus.gnt}, 32'd0);
            if (bus.gnt != 4'd0 && prev_gnt == 4'd0) handle(1'b0, bus.gnt);
            if (bus.done != 4'd0) handle(1'b1, bus.done);
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.req    = '0;
        bus.blinks = '0;

        // Reset state.
        at_neg(2);
        chk("rst_led", {31'd0, bus.led}, 32'd0);
        chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("rst_done", {28'd0, bus.done}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_flg", {31'd0, bus.flg}, 32'd0);
        at_neg(3);
        rst_ni = 1'b1;

        // Single request, two blinks.
        at_neg(5);
        k = cyc;
        bus.req    = 4'b0001;
        bus.blinks = 16'h0002;
        push(1'b0, 4'b0001, k + 1);
        push(1'b1, 4'b0001, k + 20);
        at_neg(k + 1);
        bus.req = '0;
        chk("latency_led_low", {31'd0, bus.led}, 32'd0);
        for (int off = 2; off <= 21; off++) begin
            at_neg(k + off);
            chk("single_led", {31'd0, bus.led},
                ((off >= 2 && off <= 5) || (off >= 10 && off <= 13)) ? 32'd1 : 32'd0);
        end
        chk("single_busy_after", {31'd0, bus.busy}, 32'd0);

        // Fresh reset so arbitration starts at requester 0.
        at_neg(k + 23);
        rst_ni = 1'b0;
        at_neg(k + 24);
        rst_ni = 1'b1;

        // Contention: all four requesting, one blink each.
        at_neg(k + 26);
        k = cyc;
        bus.req    = 4'b1111;
        bus.blinks = 16'h1111;
        push(1'b0, 4'b0001, k + 1);   push(1'b1, 4'b0001, k + 12);
        push(1'b0, 4'b0010, k + 14);  push(1'b1, 4'b0010, k + 25);
        push(1'b0, 4'b0100, k + 27);  push(1'b1, 4'b0100, k + 38);
        push(1'b0, 4'b1000, k + 40);  push(1'b1, 4'b1000, k + 51);
        push(1'b0, 4'b0001, k + 53);  push(1'b1, 4'b0001, k + 64);
        at_neg(k + 13);
        chk("contention_gap_idle", {31'd0, bus.busy}, 32'd0);
        at_neg(k + 53);
        bus.req = '0;

        // Zero-length burst on requester 1 behaves as one blink; flag pulses each phase end.
        at_neg(k + 67);
        k = cyc;
        bus.req    = 4'b0010;
        bus.blinks = 16'h0000;
        push(1'b0, 4'b0010, k + 1);
        push(1'b1, 4'b0010, k + 12);
        at_neg(k + 1);
        bus.req = '0;
        chk("zero_flg", {31'd0, bus.flg}, 32'd0);
        for (int off = 2; off <= 13; off++) begin
            at_neg(k + off);
            chk("zero_flg", {31'd0, bus.flg}, (off % 4 == 0 && off <= 12) ? 32'd1 : 32'd0);
            chk("zero_led", {31'd0, bus.led}, (off <= 5) ? 32'd1 : 32'd0);
        end

        // Request dropped early; blinks changed after grant must be ignored.
        at_neg(k + 15);
        k = cyc;
        bus.req    = 4'b0100;
        bus.blinks = 16'h0300;
        push(1'b0, 4'b0100, k + 1);
        push(1'b1, 4'b0100, k + 28);
        at_neg(k + 2);
        bus.req    = '0;
        bus.blinks = 16'h0100;
        at_neg(k + 32);
        chk("drop_queue_empty", q.size(), 32'd0);

        // Reset during the second ON phase abandons the burst.
        at_neg(k + 34);
        k = cyc;
        bus.req    = 4'b0001;
        bus.blinks = 16'h0012;
        push(1'b0, 4'b0001, k + 1);
        at_neg(k + 1);
        bus.req = '0;
        at_neg(k + 10);
        chk("mid_led_before", {31'd0, bus.led}, 32'd1);
        #2;
        rst_ni = 1'b0;
        bus.req = 4'b1010;
        #1;
        chk("mid_led", {31'd0, bus.led}, 32'd0);
        chk("mid_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        at_neg(k + 12);
        rst_ni = 1'b1;
        push(1'b0, 4'b0010, k + 13);
        push(1'b1, 4'b0010, k + 24);
        at_neg(k + 13);
        bus.req = '0;
        at_neg(k + 30);
        chk("final_queue_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/blink_arb.md
BLINK_ARB -- requirements
Module: blink_arb

Interface
REQ-001 Parameter CBITS, default 15: phase-counter width; each LED phase lasts 2^CBITS cycles; legal range 1..24.
REQ-002 Parameter NREQ, fixed 4: number of requesters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 req  input  4  per-requester blink-burst request, level-sensitive.
REQ-006 blinks  input  16  per-requester burst length, 4 bits each; requester i uses bits [4i+3:4i].
REQ-007 led  output  1  shared LED drive, registered.
REQ-008 gnt  output  4  one-hot grant; all-zero when no burst is active.
REQ-009 done  output  4  one-cycle pulse on the requester bit whose burst completed.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 flg  output  1  one-cycle pulse on every cycle where the phase counter equals all-ones while not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ON, OFF, GAP; the phase counter cnt (CBITS bits) SHALL count only outside IDLE and SHALL be 0 on the first cycle of every state.
REQ-013 In IDLE with req != 0, the block SHALL grant one requester by round-robin, starting the search at pointer ptr (2 bits) and proceeding upward modulo 4.
REQ-014 On grant, the block SHALL set gnt to the winner, latch its blinks field into rem (0 is loaded as 1), set ptr to winner+1 mod 4, and enter ON on the next cycle.
REQ-015 In ON, led SHALL be 1; when cnt is all-ones, the FSM SHALL enter OFF.
REQ-016 In OFF, led SHALL be 0; when cnt is all-ones, the FSM SHALL decrement rem and enter ON if rem > 1, otherwise enter GAP.
REQ-017 In GAP, led SHALL be 0; when cnt is all-ones, the FSM SHALL pulse done for the granted bit, clear gnt, and enter IDLE on the same edge.
REQ-018 Latency from req asserted in IDLE to led high SHALL be exactly 2 cycles: grant edge, then ON edge, with led registered.
REQ-019 A burst of N blinks SHALL occupy exactly (2N+1)*2^CBITS cycles from the first ON cycle to the done pulse inclusive.
REQ-020 Deasserting req during a burst SHALL NOT abort it; changes to blinks after grant SHALL be ignored.
REQ-021 After the done edge, at least one IDLE cycle SHALL occur before the next grant, so bursts never abut.
REQ-022 cnt SHALL wrap from all-ones to 0 with no extra cycle; no arithmetic overflow SHALL be visible on outputs.
REQ-023 gnt SHALL stay stable for the whole burst, and exactly one gnt bit SHALL be set whenever busy is 1.

Reset
REQ-024 While rst is low: state=IDLE, cnt=0, rem=0, ptr=0, led=0, gnt=0, done=0, busy=0, flg=0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release, arbitration SHALL restart from ptr=0.

Verification (CBITS=2, phase = 4 cycles)
REQ-026 Single request: req=0001, blinks[3:0]=2 -> gnt=0001 after 1 cycle; led pattern 4 on / 4 off / 4 on / 4 off, then 4 gap cycles; done=0001 on cycle 20 of the burst; busy low after.
REQ-027 Contention: req=1111 held, all blinks=1 -> grants in order 0001, 0010, 0100, 1000, 0001; each burst is 12 cycles, separated by 1 IDLE cycle.
REQ-028 Zero length: blinks[7:4]=0, req=0010 -> one blink (4 on, 4 off, 4 gap), then done=0010.
REQ-029 Request drop: req=0100 with blinks=3, drop req after 2 cycles -> full 3-blink burst (28 cycles), done=0100, no regrant.
REQ-030 Reset mid-burst: rst low during the second ON phase -> led, gnt, busy 0 immediately; no done pulse; with req=1010 after release, the next grant is 0010.
REQ-031 flg check: during any 1-blink burst -> exactly 3 flg pulses, each on a cycle with cnt=3.
